// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - pixel-write arbiter: CPU/debug round-robin plus optional clear engine
// Build option: define FLOW_VGA_CLEAR_EN to include the full-screen clear engine.
module vga_plot_arbiter (
    input  logic        clock,
    input  logic        resetn,
    input  logic        cpu_plot,
    input  logic [7:0]  cpu_x,
    input  logic [6:0]  cpu_y,
    input  logic [14:0] cpu_color,
    output logic        cpu_ack,
    input  logic        dbg_plot,
    input  logic [7:0]  dbg_x,
    input  logic [6:0]  dbg_y,
    input  logic [14:0] dbg_color,
    output logic        dbg_ack,
    input  logic        clear_start,
    input  logic [14:0] clear_color,
    output logic        clear_busy,
    output logic        clear_done,
    output logic        oob_err,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [14:0] vga_color,
    output logic        vga_plot
);
    localparam logic [7:0] X_MAX = 8'd160;
    localparam logic [6:0] Y_MAX = 7'd120;

    logic        last_q;        // 1: debug port was granted most recently
    logic [7:0]  vga_x_q;
    logic [6:0]  vga_y_q;
    logic [14:0] vga_color_q;
    logic        vga_plot_q;
    logic        oob_err_q;
    logic        clear_done_q;

    logic        idle;
    logic        grant_cpu;
    logic        grant_dbg;
    logic [7:0]  sel_x;
    logic [6:0]  sel_y;
    logic [14:0] sel_color;
    logic        in_bounds;

`ifdef FLOW_VGA_CLEAR_EN
    typedef enum logic {S_IDLE, S_CLEAR} state_t;
    state_t      state_q;
    logic [7:0]  scan_x_q;
    logic [6:0]  scan_y_q;
    logic [14:0] fill_color_q;

    assign idle       = resetn && (state_q == S_IDLE);
    assign clear_busy = (state_q == S_CLEAR);
`else
    logic unused_clear;
    assign unused_clear = ^{clear_start, clear_color};
    assign idle         = resetn;
    assign clear_busy   = 1'b0;
`endif

    always_comb begin
        grant_cpu = idle && cpu_plot && (!dbg_plot || last_q);
        grant_dbg = idle && dbg_plot && (!cpu_plot || !last_q);
        sel_x     = grant_cpu ? cpu_x     : dbg_x;
        sel_y     = grant_cpu ? cpu_y     : dbg_y;
        sel_color = grant_cpu ? cpu_color : dbg_color;
        in_bounds = (sel_x < X_MAX) && (sel_y < Y_MAX);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            last_q       <= 1'b1;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_color_q  <= '0;
            vga_plot_q   <= 1'b0;
            oob_err_q    <= 1'b0;
            clear_done_q <= 1'b0;
`ifdef FLOW_VGA_CLEAR_EN
            state_q      <= S_IDLE;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
            fill_color_q <= '0;
`endif
        end else begin
            vga_plot_q   <= 1'b0;
            oob_err_q    <= 1'b0;
            clear_done_q <= 1'b0;
            // Out-of-bounds requests are still consumed so the requester never hangs.
            if (grant_cpu || grant_dbg) begin
                last_q      <= grant_dbg;
                vga_x_q     <= sel_x;
                vga_y_q     <= sel_y;
                vga_color_q <= sel_color;
                vga_plot_q  <= in_bounds;
                oob_err_q   <= !in_bounds;
            end
`ifdef FLOW_VGA_CLEAR_EN
            case (state_q)
                S_IDLE: begin
                    if (clear_start) begin
                        state_q      <= S_CLEAR;
                        fill_color_q <= clear_color;
                        scan_x_q     <= '0;
                        scan_y_q     <= '0;
                    end
                end
                S_CLEAR: begin
                    vga_x_q     <= scan_x_q;
                    vga_y_q     <= scan_y_q;
                    vga_color_q <= fill_color_q;
                    vga_plot_q  <= 1'b1;
                    if (scan_x_q == X_MAX - 8'd1) begin
                        scan_x_q <= '0;
                        if (scan_y_q == Y_MAX - 7'd1) begin
                            state_q      <= S_IDLE;
                            clear_done_q <= 1'b1;
                        end else begin
                            scan_y_q <= scan_y_q + 7'd1;
                        end
                    end else begin
                        scan_x_q <= scan_x_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
`endif
        end
    end

    assign cpu_ack    = grant_cpu;
    assign dbg_ack    = grant_dbg;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_color  = vga_color_q;
    assign vga_plot   = vga_plot_q;
    assign oob_err    = oob_err_q;
    assign clear_done = clear_done_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - directed self-checking bench for vga_plot_arbiter
module tb_vga_plot_arbiter;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cpu_plot = 1'b0;
    logic [7:0]  cpu_x = '0;
    logic [6:0]  cpu_y = '0;
    logic [14:0] cpu_color = '0;
    logic        cpu_ack;
    logic        dbg_plot = 1'b0;
    logic [7:0]  dbg_x = '0;
    logic [6:0]  dbg_y = '0;
    logic [14:0] dbg_color = '0;
    logic        dbg_ack;
    logic        clear_start = 1'b0;
    logic [14:0] clear_color = '0;
    logic        clear_busy;
    logic        clear_done;
    logic        oob_err;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [14:0] vga_color;
    logic        vga_plot;

    int errors = 0;
    int checks = 0;
    int busy_cnt, pix, color_bad, gaps, done_cnt, ack_bad;
    logic [14:0] first_xy, xy_160, last_xy;
    logic        exit_ack, exit_done;

    vga_plot_arbiter dut (
        .clock(clock), .resetn(resetn),
        .cpu_plot(cpu_plot), .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_color(cpu_color), .cpu_ack(cpu_ack),
        .dbg_plot(dbg_plot), .dbg_x(dbg_x), .dbg_y(dbg_y), .dbg_color(dbg_color), .dbg_ack(dbg_ack),
        .clear_start(clear_start), .clear_color(clear_color),
        .clear_busy(clear_busy), .clear_done(clear_done), .oob_err(oob_err),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_pixel(input string tag, input logic [7:0] x, input logic [6:0] y,
                               input logic [14:0] c, input logic p, input logic e);
        check_eq({tag, "_x"}, {24'd0, vga_x}, {24'd0, x});
        check_eq({tag, "_y"}, {25'd0, vga_y}, {25'd0, y});
        check_eq({tag, "_color"}, {17'd0, vga_color}, {17'd0, c});
        check_eq({tag, "_plot"}, {31'd0, vga_plot}, {31'd0, p});
        check_eq({tag, "_oob"}, {31'd0, oob_err}, {31'd0, e});
    endtask

    initial begin
        tick;
        tick;
        check_pixel("reset", 8'd0, 7'd0, 15'd0, 1'b0, 1'b0);
        check_eq("reset_busy", {31'd0, clear_busy}, 32'd0);
        check_eq("reset_done", {31'd0, clear_done}, 32'd0);
        resetn = 1'b1;

        // single CPU pixel
        cpu_plot = 1'b1; cpu_x = 8'd10; cpu_y = 7'd20; cpu_color = 15'h7FFF;
        #1;
        check_eq("cpu_ack_single", {31'd0, cpu_ack}, 32'd1);
        check_eq("dbg_ack_single", {31'd0, dbg_ack}, 32'd0);
        tick;
        cpu_plot = 1'b0;
        check_pixel("cpu_px", 8'd10, 7'd20, 15'h7FFF, 1'b1, 1'b0);

        // single debug pixel, leaves last pointer on debug
        dbg_plot = 1'b1; dbg_x = 8'd3; dbg_y = 7'd4; dbg_color = 15'h1234;
        #1;
        check_eq("dbg_ack_single", {31'd0, dbg_ack}, 32'd1);
        tick;
        dbg_plot = 1'b0;
        check_pixel("dbg_px", 8'd3, 7'd4, 15'h1234, 1'b1, 1'b0);

        // contended: CPU, dbg, CPU, dbg
        cpu_plot = 1'b1; cpu_x = 8'd1; cpu_y = 7'd1; cpu_color = 15'h0111;
        dbg_plot = 1'b1; dbg_x = 8'd2; dbg_y = 7'd2; dbg_color = 15'h0222;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("rr_cpu_ack", {31'd0, cpu_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("rr_dbg_ack", {31'd0, dbg_ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick;
            check_pixel("rr_px", (i % 2 == 0) ? 8'd1 : 8'd2, (i % 2 == 0) ? 7'd1 : 7'd2,
                        (i % 2 == 0) ? 15'h0111 : 15'h0222, 1'b1, 1'b0);
        end
        cpu_plot = 1'b0; dbg_plot = 1'b0;
        tick;
        check_eq("idle_plot", {31'd0, vga_plot}, 32'd0);

        // bounds
        dbg_plot = 1'b1; dbg_x = 8'd160; dbg_y = 7'd5; dbg_color = 15'h0F0F;
        #1;
        check_eq("oob_x_ack", {31'd0, dbg_ack}, 32'd1);
        tick;
        dbg_x = 8'd0; dbg_y = 7'd120;
        check_eq("oob_x_plot", {31'd0, vga_plot}, 32'd0);
        check_eq("oob_x_err", {31'd0, oob_err}, 32'd1);
        #1;
        check_eq("oob_y_ack", {31'd0, dbg_ack}, 32'd1);
        tick;
        dbg_plot = 1'b0;
        check_eq("oob_y_plot", {31'd0, vga_plot}, 32'd0);
        check_eq("oob_y_err", {31'd0, oob_err}, 32'd1);
        cpu_plot = 1'b1; cpu_x = 8'd159; cpu_y = 7'd119; cpu_color = 15'h2222;
        tick;
        cpu_plot = 1'b0;
        check_pixel("edge_px", 8'd159, 7'd119, 15'h2222, 1'b1, 1'b0);

`ifdef FLOW_VGA_CLEAR_EN
        // fill with same-cycle CPU grant
        clear_start = 1'b1; clear_color = 15'h001F;
        cpu_plot = 1'b1; cpu_x = 8'd5; cpu_y = 7'd6; cpu_color = 15'h0ABC;
        #1;
        check_eq("start_cpu_ack", {31'd0, cpu_ack}, 32'd1);
        tick;
        clear_start = 1'b0;
        cpu_x = 8'd7; cpu_y = 7'd8; cpu_color = 15'h5555;
        check_pixel("start_cpu_px", 8'd5, 7'd6, 15'h0ABC, 1'b1, 1'b0);
        check_eq("busy_rise", {31'd0, clear_busy}, 32'd1);
        #1;
        check_eq("stall_ack", {31'd0, cpu_ack}, 32'd0);
        busy_cnt = 1; pix = 0; color_bad = 0; gaps = 0; done_cnt = 0; ack_bad = 0;
        first_xy = '0; xy_160 = '0; last_xy = '0; exit_ack = 1'b0; exit_done = 1'b0;
        for (int n = 0; n < 19300; n++) begin
            tick;
            if (vga_plot) begin
                pix++;
                if (pix == 1) first_xy = {vga_x, vga_y};
                if (pix == 160) xy_160 = {vga_x, vga_y};
                if (vga_color != 15'h001F) color_bad++;
            end else begin
                gaps++;
            end
            if (clear_done) done_cnt++;
            if (!clear_busy) begin
                exit_ack = cpu_ack; exit_done = clear_done; last_xy = {vga_x, vga_y};
                break;
            end
            busy_cnt++;
            if (cpu_ack) ack_bad++;
        end
        check_eq("fill_busy_cycles", busy_cnt, 32'd19200);
        check_eq("fill_pixels", pix, 32'd19200);
        check_eq("fill_gaps", gaps, 32'd0);
        check_eq("fill_first", {17'd0, first_xy}, {17'd0, 8'd0, 7'd0});
        check_eq("fill_160th", {17'd0, xy_160}, {17'd0, 8'd159, 7'd0});
        check_eq("fill_last", {17'd0, last_xy}, {17'd0, 8'd159, 7'd119});
        check_eq("fill_color_bad", color_bad, 32'd0);
        check_eq("fill_done_at_end", {31'd0, exit_done}, 32'd1);
        check_eq("fill_stall_acks", ack_bad, 32'd0);
        check_eq("fill_exit_ack", {31'd0, exit_ack}, 32'd1);
        tick;
        cpu_plot = 1'b0;
        check_pixel("post_fill_px", 8'd7, 7'd8, 15'h5555, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            tick;
            if (clear_done) done_cnt++;
        end
        check_eq("fill_done_count", done_cnt, 32'd1);

        // second fill, reset at pixel 500
        clear_start = 1'b1; clear_color = 15'h03E0;
        tick;
        clear_start = 1'b0;
        for (int n = 0; n < 500; n++) tick;
        check_pixel("fill_px500", 8'd19, 7'd3, 15'h03E0, 1'b1, 1'b0);
`else
        // clear engine absent: start pulse ignored, requests not stalled
        clear_start = 1'b1; clear_color = 15'h001F;
        tick;
        clear_start = 1'b0;
        check_eq("noclr_busy", {31'd0, clear_busy}, 32'd0);
        cpu_plot = 1'b1; cpu_x = 8'd7; cpu_y = 7'd8; cpu_color = 15'h5555;
        #1;
        check_eq("noclr_ack", {31'd0, cpu_ack}, 32'd1);
        tick;
        cpu_plot = 1'b0;
        check_pixel("noclr_px", 8'd7, 7'd8, 15'h5555, 1'b1, 1'b0);
        check_eq("noclr_done", {31'd0, clear_done}, 32'd0);
        tick;
        check_eq("noclr_idle_plot", {31'd0, vga_plot}, 32'd0);
`endif

        // reset with both ports requesting
        resetn = 1'b0;
        cpu_plot = 1'b1; cpu_x = 8'd9; cpu_y = 7'd9; cpu_color = 15'h0099;
        dbg_plot = 1'b1; dbg_x = 8'd11; dbg_y = 7'd11; dbg_color = 15'h00BB;
        #1;
        check_eq("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        check_eq("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
        tick;
        check_pixel("rst_out", 8'd0, 7'd0, 15'd0, 1'b0, 1'b0);
        check_eq("rst_busy", {31'd0, clear_busy}, 32'd0);
        check_eq("rst_done", {31'd0, clear_done}, 32'd0);
        resetn = 1'b1;
        #1;
        check_eq("post_rst_cpu_ack", {31'd0, cpu_ack}, 32'd1);
        check_eq("post_rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
        tick;
        cpu_plot = 1'b0;
        check_pixel("post_rst_cpu_px", 8'd9, 7'd9, 15'h0099, 1'b1, 1'b0);
        #1;
        check_eq("post_rst_dbg_ack2", {31'd0, dbg_ack}, 32'd1);
        tick;
        dbg_plot = 1'b0;
        check_pixel("post_rst_dbg_px", 8'd11, 7'd11, 15'h00BB, 1'b1, 1'b0);
        done_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            tick;
            if (clear_done || clear_busy) done_cnt++;
        end
        check_eq("abort_no_done", done_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
